// File: rtl/cpu_mc_pkg.sv
// Shared types for the multi-cycle 16-bit CPU: FSM states, opcodes and the link register.
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_FWAIT,
    ST_EXEC,
    ST_MEM,
    ST_MWAIT
  } state_t;

  typedef enum logic [3:0] {
    OP_MV   = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_CMP  = 4'h3,
    OP_LD   = 4'h4,
    OP_ST   = 4'h5,
    OP_MVHI = 4'h6,
    OP_JR   = 4'h8,
    OP_JZ   = 4'h9,
    OP_JN   = 4'hA,
    OP_CALL = 4'hC
  } opcode_t;

  localparam logic [2:0] LINK_REG = 3'd7;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write port.
module cpu_mc_regfile
  import cpu_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  i_raddr_a,
  output logic [15:0] o_rdata_a,
  input  logic [2:0]  i_raddr_b,
  output logic [15:0] o_rdata_b,
  input  logic        i_we,
  input  logic [2:0]  i_waddr,
  input  logic [15:0] i_wdata
);

  logic [15:0] r_regs [8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle 16-bit CPU: FETCH -> FWAIT -> EXEC [-> MEM [-> MWAIT]] over a
// single waitrequest-style memory port.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_wrdata,
  input  logic [15:0] i_mem_rddata,
  input  logic        i_mem_waitrequest,
  output logic [15:0] o_pc,
  output logic        o_instr_done
);

  localparam logic [15:0] ADDR_MASK = 16'((32'h1 << ADDR_W) - 32'h1);

  state_t      r_state;
  logic [15:0] r_pc, r_ir;
  logic        r_n, r_z;

  opcode_t     w_op;
  logic        w_imm, w_is_ld, w_is_st, w_accept, w_take, w_we;
  logic [2:0]  w_rx, w_ry, w_waddr;
  logic [15:0] w_rx_val, w_ry_val, w_opb, w_sum, w_diff, w_flag_res;
  logic [15:0] w_jtarget, w_wdata;

  assign w_op     = opcode_t'(r_ir[3:0]);
  assign w_imm    = r_ir[4];
  assign w_rx     = r_ir[7:5];
  assign w_ry     = r_ir[10:8];
  assign w_is_ld  = (w_op == OP_LD);
  assign w_is_st  = (w_op == OP_ST);
  assign w_accept = !i_mem_waitrequest;

  cpu_mc_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_raddr_a (w_rx),
    .o_rdata_a (w_rx_val),
    .i_raddr_b (w_ry),
    .o_rdata_b (w_ry_val),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata)
  );

  assign w_opb      = w_imm ? sext8(r_ir[15:8]) : w_ry_val;
  assign w_sum      = w_rx_val + w_opb;
  assign w_diff     = w_rx_val - w_opb;
  assign w_flag_res = (w_op == OP_ADD) ? w_sum : w_diff;
  // r_pc already points past this instruction while in EXEC
  assign w_jtarget  = w_imm ? r_pc + {{4{r_ir[15]}}, r_ir[15:5], 1'b0} : w_rx_val;

  always_comb begin
    w_take  = 1'b0;
    w_we    = 1'b0;
    w_waddr = w_rx;
    w_wdata = w_opb;
    if (r_state == ST_EXEC) begin
      case (w_op)
        OP_MV:   w_we = 1'b1;
        OP_ADD:  begin w_we = 1'b1; w_wdata = w_sum;  end
        OP_SUB:  begin w_we = 1'b1; w_wdata = w_diff; end
        OP_MVHI: begin w_we = 1'b1; w_wdata = {r_ir[15:8], w_rx_val[7:0]}; end
        OP_JR:   w_take = 1'b1;
        OP_JZ:   w_take = r_z;
        OP_JN:   w_take = r_n;
        OP_CALL: begin
          w_take  = 1'b1;
          w_we    = 1'b1;
          w_waddr = LINK_REG;
          w_wdata = r_pc;
        end
        default: ;
      endcase
    end else if (r_state == ST_MWAIT) begin
      w_we    = 1'b1;
      w_wdata = i_mem_rddata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: if (w_accept) r_state <= ST_FWAIT;
        ST_FWAIT: begin
          r_ir    <= i_mem_rddata;
          r_pc    <= r_pc + 16'd2;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_is_ld || w_is_st) begin
            r_state <= ST_MEM;
          end else begin
            r_state <= ST_FETCH;
            if (w_take) r_pc <= w_jtarget;
            if (w_op == OP_ADD || w_op == OP_SUB || w_op == OP_CMP) begin
              r_n <= w_flag_res[15];
              r_z <= (w_flag_res == 16'h0000);
            end
          end
        end
        ST_MEM:   if (w_accept) r_state <= w_is_ld ? ST_MWAIT : ST_FETCH;
        ST_MWAIT: r_state <= ST_FETCH;
        default:  r_state <= ST_FETCH;
      endcase
    end
  end

  // Requests are decoded from state and masked by reset so an in-flight access drops at once.
  assign o_mem_rd     = !reset && ((r_state == ST_FETCH) || (r_state == ST_MEM && w_is_ld));
  assign o_mem_wr     = !reset && (r_state == ST_MEM) && w_is_st;
  assign o_mem_addr   = ((r_state == ST_MEM) ? w_ry_val : r_pc) & ADDR_MASK;
  assign o_mem_wrdata = o_mem_wr ? w_rx_val : 16'h0000;
  assign o_pc         = r_pc;
  assign o_instr_done = !reset && (
                          (r_state == ST_EXEC && !w_is_ld && !w_is_st) ||
                          (r_state == ST_MEM && w_is_st && w_accept) ||
                          (r_state == ST_MWAIT));

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: table-driven program walk plus wait-state and reset-abort sequences.
module tb_cpu_mc;

  localparam logic [15:0] RPC = 16'h0040;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] o_mem_addr, o_mem_wrdata, o_pc, i_mem_rddata;
  logic        o_mem_rd, o_mem_wr, o_instr_done, i_mem_waitrequest;

  int checks = 0;
  int errors = 0;

  cpu_mc #(.ADDR_W(16), .RESET_PC(RPC)) dut (
    .clk               (clk),
    .reset             (reset),
    .o_mem_addr        (o_mem_addr),
    .o_mem_rd          (o_mem_rd),
    .o_mem_wr          (o_mem_wr),
    .o_mem_wrdata      (o_mem_wrdata),
    .i_mem_rddata      (i_mem_rddata),
    .i_mem_waitrequest (i_mem_waitrequest),
    .o_pc              (o_pc),
    .o_instr_done      (o_instr_done)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, write log, and a preload port for the bench.
  logic [15:0] mem [1024];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  int          wr_cnt = 0;
  logic [15:0] last_wr_addr = '0, last_wr_data = '0;

  always @(posedge clk) begin
    if (o_mem_rd && !i_mem_waitrequest) i_mem_rddata <= mem[o_mem_addr[10:1]];
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (o_mem_wr && !i_mem_waitrequest) begin
      mem[o_mem_addr[10:1]] <= o_mem_wrdata;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= o_mem_addr;
      last_wr_data <= o_mem_wrdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] byte_addr, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = byte_addr[10:1];
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  function automatic logic [15:0] peek(input int i);
    case (i)
      0: return dut.u_regfile.r_regs[0];
      1: return dut.u_regfile.r_regs[1];
      2: return dut.u_regfile.r_regs[2];
      3: return dut.u_regfile.r_regs[3];
      4: return dut.u_regfile.r_regs[4];
      5: return dut.u_regfile.r_regs[5];
      6: return dut.u_regfile.r_regs[6];
      default: return dut.u_regfile.r_regs[7];
    endcase
  endfunction

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {5'b0, ry, rx, 1'b0, op};
  endfunction
  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rx, input logic [7:0] imm);
    return {imm, rx, 1'b1, op};
  endfunction
  function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [10:0] imm);
    return {imm, 1'b1, op};
  endfunction

  // Called at the first (FETCH) cycle of an instruction; returns at the next one.
  task automatic step(input logic [15:0] pc, input int lat, input string nm);
    int n;
    n = 0;
    chk({nm, " fetch_rd"}, o_mem_rd, 1);
    chk({nm, " fetch_addr"}, o_mem_addr, pc);
    while (o_instr_done !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    n++;
    chk({nm, " latency"}, n, lat);
    $display("instr %-8s pc=%04h latency=%0d", nm, pc, n);
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    int          lat;
    int          rsel;
    logic [15:0] rval;
    logic        n;
    logic        z;
    string       nm;
  } vec_t;

  vec_t vecs[23];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    i_mem_waitrequest = 1'b0;
    #2 reset = 1'b1;

    vecs[0]  = '{16'h0040, enc_i(4'h0, 3'd1, 8'h05), 3, 1, 16'h0005, 1'b0, 1'b0, "mvi"};
    vecs[1]  = '{16'h0042, enc_i(4'h1, 3'd1, 8'hFB), 3, 1, 16'h0000, 1'b0, 1'b1, "addi"};
    vecs[2]  = '{16'h0044, enc_i(4'h0, 3'd2, 8'h34), 3, 2, 16'h0034, 1'b0, 1'b1, "mvi"};
    vecs[3]  = '{16'h0046, enc_i(4'h6, 3'd2, 8'h12), 3, 2, 16'h1234, 1'b0, 1'b1, "mvhi"};
    vecs[4]  = '{16'h0048, enc_i(4'h6, 3'd3, 8'h01), 3, 3, 16'h0100, 1'b0, 1'b1, "mvhi"};
    vecs[5]  = '{16'h004A, enc_r(4'h5, 3'd2, 3'd3),  4, 2, 16'h1234, 1'b0, 1'b1, "st"};
    vecs[6]  = '{16'h004C, enc_r(4'h4, 3'd4, 3'd3),  5, 4, 16'h1234, 1'b0, 1'b1, "ld"};
    vecs[7]  = '{16'h004E, enc_i(4'h3, 3'd0, 8'h00), 3, 0, 16'h0000, 1'b0, 1'b1, "cmpi"};
    vecs[8]  = '{16'h0050, enc_j(4'h8, 11'h7DF),     3, 1, 16'h0000, 1'b0, 1'b1, "j"};
    vecs[9]  = '{16'h0010, enc_j(4'h9, 11'd4),       3, 1, 16'h0000, 1'b0, 1'b1, "jz_t"};
    vecs[10] = '{16'h001A, enc_i(4'h3, 3'd0, 8'h01), 3, 0, 16'h0000, 1'b1, 1'b0, "cmpi"};
    vecs[11] = '{16'h001C, enc_j(4'h8, 11'h7F9),     3, 2, 16'h1234, 1'b1, 1'b0, "j"};
    vecs[12] = '{16'h0010, enc_j(4'h9, 11'd4),       3, 3, 16'h0100, 1'b1, 1'b0, "jz_nt"};
    vecs[13] = '{16'h0012, enc_j(4'hA, 11'd6),       3, 4, 16'h1234, 1'b1, 1'b0, "jn_t"};
    vecs[14] = '{16'h0020, enc_j(4'hC, 11'h7F0),     3, 7, 16'h0022, 1'b1, 1'b0, "call"};
    vecs[15] = '{16'h0002, enc_r(4'hC, 3'd7, 3'd0),  3, 7, 16'h0004, 1'b1, 1'b0, "callr"};
    vecs[16] = '{16'h0022, 16'hFF27,                 3, 1, 16'h0000, 1'b1, 1'b0, "rsv7"};
    vecs[17] = '{16'h0024, 16'h7FFB,                 3, 7, 16'h0004, 1'b1, 1'b0, "rsvB"};
    vecs[18] = '{16'h0026, enc_r(4'h2, 3'd5, 3'd2),  3, 5, 16'hEDCC, 1'b1, 1'b0, "sub"};
    vecs[19] = '{16'h0028, enc_r(4'h1, 3'd5, 3'd2),  3, 5, 16'h0000, 1'b0, 1'b1, "add"};
    vecs[20] = '{16'h002A, enc_r(4'h0, 3'd6, 3'd4),  3, 6, 16'h1234, 1'b0, 1'b1, "mv"};
    vecs[21] = '{16'h002C, enc_j(4'hA, 11'd100),     3, 6, 16'h1234, 1'b0, 1'b1, "jn_nt"};
    vecs[22] = '{16'h002E, enc_r(4'h8, 3'd3, 3'd0),  3, 3, 16'h0100, 1'b0, 1'b1, "jr"};

    // ---- program load and reset state ----
    @(negedge clk);
    foreach (vecs[i]) load(vecs[i].pc, vecs[i].instr);
    chk("rst mem_rd", o_mem_rd, 0);
    chk("rst mem_wr", o_mem_wr, 0);
    chk("rst done", o_instr_done, 0);
    chk("rst wrdata", o_mem_wrdata, 0);
    chk("rst pc", o_pc, RPC);
    reset = 1'b0;
    #1;

    // ---- table-driven program walk ----
    foreach (vecs[i]) begin
      step(vecs[i].pc, vecs[i].lat, vecs[i].nm);
      chk({vecs[i].nm, " reg"}, peek(vecs[i].rsel), vecs[i].rval);
      chk({vecs[i].nm, " N"}, dut.r_n, vecs[i].n);
      chk({vecs[i].nm, " Z"}, dut.r_z, vecs[i].z);
    end
    chk("jr target fetch", o_mem_addr, 16'h0100);
    chk("st write count", wr_cnt, 1);
    chk("st write addr", last_wr_addr, 16'h0100);
    chk("st write data", last_wr_data, 16'h1234);

    // ---- asynchronous reset clears architectural state ----
    #2 reset = 1'b1;
    #1;
    chk("areset rd", o_mem_rd, 0);
    chk("areset pc", o_pc, RPC);
    chk("areset R4", peek(4), 0);
    chk("areset N", dut.r_n, 0);
    chk("areset Z", dut.r_z, 0);

    // ---- waitrequest stalls during fetch and ld ----
    @(negedge clk);
    load(16'h0000, 16'hBEEF);
    load(RPC, enc_r(4'h4, 3'd5, 3'd0));
    reset = 1'b0;
    #1;
    for (int c = 1; c <= 11; c++) begin
      i_mem_waitrequest = (c <= 3) || (c >= 7 && c <= 9);
      chk($sformatf("wait c%0d done", c), o_instr_done, (c == 11));
      chk($sformatf("wait c%0d wr", c), o_mem_wr, 0);
      if (c <= 4) begin
        chk($sformatf("wait c%0d fetch rd", c), o_mem_rd, 1);
        chk($sformatf("wait c%0d fetch addr", c), o_mem_addr, RPC);
      end else if (c >= 7 && c <= 10) begin
        chk($sformatf("wait c%0d ld rd", c), o_mem_rd, 1);
        chk($sformatf("wait c%0d ld addr", c), o_mem_addr, 16'h0000);
      end else begin
        chk($sformatf("wait c%0d idle rd", c), o_mem_rd, 0);
      end
      @(negedge clk);
      #1;
    end
    i_mem_waitrequest = 1'b0;
    chk("wait ld R5", peek(5), 16'hBEEF);
    chk("wait next fetch", o_mem_addr, RPC + 16'd2);
    $display("seq wait-state ld: 11 cycles, R5=%04h", peek(5));

    // ---- reset in the middle of a stalled st ----
    reset = 1'b1;
    @(negedge clk);
    load(RPC, enc_i(4'h0, 3'd2, 8'h55));
    load(RPC + 16'd2, enc_r(4'h5, 3'd2, 3'd3));
    reset = 1'b0;
    #1;
    step(RPC, 3, "mvi");
    chk("abort st fetch", o_mem_addr, RPC + 16'd2);
    @(negedge clk);
    @(negedge clk);
    i_mem_waitrequest = 1'b1;
    @(negedge clk);
    chk("abort st wr", o_mem_wr, 1);
    chk("abort st addr", o_mem_addr, 16'h0000);
    chk("abort st wrdata", o_mem_wrdata, 16'h0055);
    #2 reset = 1'b1;
    #1;
    chk("abort wr drop", o_mem_wr, 0);
    chk("abort wrdata", o_mem_wrdata, 0);
    chk("abort rd", o_mem_rd, 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort no write", wr_cnt, 1);
    chk("abort R2 cleared", peek(2), 0);
    i_mem_waitrequest = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort refetch rd", o_mem_rd, 1);
    chk("abort refetch addr", o_mem_addr, RPC);
    $display("seq reset-abort st: writes=%0d refetch=%04h", wr_cnt, o_mem_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
